// File: rtl/multu_hilo_unit.sv
// Execute-stage unsigned multiply / HI-LO unit.
// Performs an iterative shift-add multiply (multu) or multiply-accumulate (maddu)
// into HI:LO, serves mfhi/mflo reads, and stalls EX while a multiply is in flight.
module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [1:0]       mul,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_MADDU = 2'b10;
  localparam logic [1:0] SEL_HI   = 2'b01;
  localparam logic [1:0] SEL_LO   = 2'b10;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic               maddu_q, maddu_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               mul_req;
  logic               rd_hi;
  logic               rd_lo;
  logic               accept;
  logic               last_iter;

  // Request decode: a valid mul code wins over sel; reserved codes are no request.
  always_comb begin
    mul_req   = en && ((mul == OP_MULTU) || (mul == OP_MADDU));
    rd_hi     = en && (mul == 2'b00) && (sel == SEL_HI);
    rd_lo     = en && (mul == 2'b00) && (sel == SEL_LO);
    accept    = (state_q == S_IDLE) && mul_req && !flush;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush abandons RUN/WB without writeback.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (flush)          state_d = S_IDLE;
        else if (last_iter) state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, shift-add step, HI:LO writeback.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    maddu_d  = maddu_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d  = PW'(opa);
          mplier_d = opb;
          prod_d   = '0;
          cnt_d    = '0;
          maddu_d  = (mul == OP_MADDU);
        end
      end
      S_RUN: begin
        if (!flush) begin
          if (mplier_q[0]) prod_d = prod_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        if (!flush) begin
          // Accumulate wraps modulo 2^(2*WIDTH); the carry out is dropped.
          {hi_d, lo_d} = maddu_q ? ({hi_q, lo_q} + prod_q) : prod_q;
          done_d       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything immediately, even mid-multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      maddu_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      maddu_q  <= maddu_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Outputs: read mux and stall are combinational, the rest come from flops.
  always_comb begin
    busy  = (state_q != S_IDLE);
    stall = busy && (mul_req || rd_hi || rd_lo);
    if (rd_hi)      dout = hi_q;
    else if (rd_lo) dout = lo_q;
    else            dout = '0;
    done  = done_q;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench for multu_hilo_unit: directed table, hand-written
// stall/flush/reset sequences and random ops against a 64-bit arithmetic model.
module tb_multu_hilo_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         flush;
  logic [1:0]   mul;
  logic [1:0]   sel;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic [W-1:0] dout;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  // Reference HI:LO kept as one 64-bit number.
  logic [63:0] hl_m;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  vec_t vecs[7];

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .mul(mul), .sel(sel),
    .opa(opa), .opb(opb), .dout(dout), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_op(input logic [1:0] m, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [63:0] prev);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return (m == 2'b10) ? prev + p : p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen; n returns the number of edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  // Issue one op from IDLE and follow it to completion with timing checks.
  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    en = 1'b1; mul = m; sel = 2'b00; opa = a; opb = b;
    #1;
    chk("accept_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    en = 1'b0; mul = 2'b00;
    opa = $urandom; opb = $urandom;
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_done(n);
    chk("latency", 64'(n), 64'(LAT));
    hl_m = model_op(m, a, b, hl_m);
    chk("hilo_model", {hi, lo}, hl_m);
    chk("busy_in_done", 64'(busy), 64'd0);
    step();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic rd_check(input logic [W-1:0] eh, input logic [W-1:0] el);
    en = 1'b1; mul = 2'b00; sel = 2'b01;
    #1;
    chk("mfhi", 64'(dout), 64'(eh));
    chk("mfhi_stall", 64'(stall), 64'd0);
    sel = 2'b10;
    #1;
    chk("mflo", 64'(dout), 64'(el));
    en = 1'b0; sel = 2'b00;
  endtask

  initial begin
    int n;
    bit done_seen;
    logic [W-1:0] c, d;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b10, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0007};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    rst_n = 1'b1; en = 1'b0; flush = 1'b0; mul = 2'b00; sel = 2'b00;
    opa = '0; opb = '0; hl_m = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Directed table, including the 2^64 wrap of maddu.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].m, vecs[i].a, vecs[i].b);
      chk("table_hi", 64'(hi), 64'(vecs[i].eh));
      chk("table_lo", 64'(lo), 64'(vecs[i].el));
      rd_check(vecs[i].eh, vecs[i].el);
    end

    // Stall: mfhi then a second multu held during busy; multu accepted in done cycle.
    c = $urandom; d = $urandom;
    en = 1'b1; mul = 2'b01; opa = 32'h0000_BEEF; opb = 32'h0012_3456;
    step();
    en = 1'b0; mul = 2'b00;
    repeat (4) step();
    en = 1'b1; sel = 2'b01;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (n == 8) begin mul = 2'b01; opa = c; opb = d; end
      #1;
      chk("stall_while_busy", 64'(stall), 64'd1);
      step();
      n++;
    end
    hl_m = model_op(2'b01, 32'h0000_BEEF, 32'h0012_3456, hl_m);
    chk("stall_seq_done", 64'(done), 64'd1);
    chk("stall_seq_hilo", {hi, lo}, hl_m);
    chk("done_cycle_stall", 64'(stall), 64'd0);
    step();
    mul = 2'b00;
    chk("b2b_accepted", 64'(busy), 64'd1);
    opa = $urandom; opb = $urandom;
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'(LAT));
    hl_m = model_op(2'b01, c, d, hl_m);
    #1;
    chk("post_done_mfhi", 64'(dout), 64'(hl_m[63:32]));
    chk("post_done_stall", 64'(stall), 64'd0);
    en = 1'b0; sel = 2'b00;
    step();

    // Flush: prior HI:LO = 1:2, multu 7*9 flushed mid-RUN, then flushed in WB.
    run_op(2'b01, 32'h0000_0002, 32'h8000_0001);
    chk("preload", {hi, lo}, 64'h0000_0001_0000_0002);
    en = 1'b1; mul = 2'b01; opa = 32'd7; opb = 32'd9;
    step();
    en = 1'b0; mul = 2'b00;
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_run_busy", 64'(busy), 64'd0);
    done_seen = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("flush_run_nodone", 64'(done_seen), 64'd0);
    chk("flush_run_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
    en = 1'b1; mul = 2'b01; opa = 32'd7; opb = 32'd9;
    step();
    en = 1'b0; mul = 2'b00;
    repeat (W) step();
    chk("in_wb_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wb_done", 64'(done), 64'd0);
    chk("flush_wb_busy", 64'(busy), 64'd0);
    chk("flush_wb_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
    en = 1'b1; mul = 2'b01; flush = 1'b1;
    step();
    en = 1'b0; mul = 2'b00; flush = 1'b0;
    chk("flush_idle_block", 64'(busy), 64'd0);

    // Reserved codes: no start, no stall, dout 0 (also while busy).
    en = 1'b1; mul = 2'b11; sel = 2'b00;
    #1;
    chk("mul11_stall", 64'(stall), 64'd0);
    step();
    chk("mul11_nostart", 64'(busy), 64'd0);
    mul = 2'b00; sel = 2'b11;
    #1;
    chk("sel11_dout", 64'(dout), 64'd0);
    chk("sel11_stall", 64'(stall), 64'd0);
    sel = 2'b00; mul = 2'b01; opa = 32'd5; opb = 32'd5;
    step();
    mul = 2'b11;
    #1;
    chk("mul11_busy_stall", 64'(stall), 64'd0);
    en = 1'b0; mul = 2'b00;
    wait_done(n);
    hl_m = model_op(2'b01, 32'd5, 32'd5, hl_m);
    chk("mul11_busy_result", {hi, lo}, hl_m);

    // Async reset in the done cycle, then mid-RUN.
    en = 1'b1; mul = 2'b01; opa = 32'hFFFF_0000; opb = 32'h0001_FFFF;
    step();
    en = 1'b0; mul = 2'b00;
    wait_done(n);
    chk("pre_rst_done", 64'(done), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    hl_m = '0;
    run_op(2'b01, 32'h0000_1234, 32'h0000_5678);
    en = 1'b1; mul = 2'b10; opa = 32'hDEAD_BEEF; opb = 32'h0BAD_F00D;
    step();
    en = 1'b0; mul = 2'b00;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run_busy", 64'(busy), 64'd0);
    chk("arst_run_hilo", {hi, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    hl_m = '0;
    done_seen = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) done_seen = 1'b1;
    end
    chk("arst_no_wb", 64'(done_seen), 64'd0);
    chk("arst_hilo_stays", {hi, lo}, 64'd0);

    // Random multu/maddu against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   m;
      logic [W-1:0] a, b;
      m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      a = $urandom;
      b = $urandom;
      if (i % 6 == 5) a = 32'hFFFF_FFFF;
      if (i % 7 == 6) b = 32'h0000_0000;
      run_op(m, a, b);
      rd_check(hl_m[63:32], hl_m[31:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
